point_stepper: RTL and testbench

Frame-level sequencer that owns the per-point physics state (position, velocity) of the squishy car and drives the `update_point` begin/result handshake from the initiator side. On each `step_in` it walks points 0..N-1, launches one `update_point` request per point, waits for the result pulse, and writes the new state back. It sits between the frame timer and `update_point`, and exposes a read port for the renderer and a load port for initial placement.

---
 rtl/physics_pkg.sv | 28 ++
 rtl/point_stepper_regfile.sv | 60 ++++++
 rtl/point_stepper.sv | 149 ++++++++++++++
 tb/tb_point_stepper.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/physics_pkg.sv
// Shared types for the squishy-car point stepper: FSM states, point record,
// and the index-width helper.
package physics_pkg;

    localparam int POS_W = 8;
    localparam int VEL_W = 8;

    // $clog2 that never returns 0, so 1-entry files still get a 1-bit index
    function automatic int pidx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_WRITE,
        S_DONE
    } stepper_state_t;

    typedef struct packed {
        logic signed [POS_W-1:0] pos_x;
        logic signed [POS_W-1:0] pos_y;
        logic signed [VEL_W-1:0] vel_x;
        logic signed [VEL_W-1:0] vel_y;
    } point_t;

endpackage

// File: rtl/point_stepper_regfile.sv
// Per-point state storage: one write port, an async read port for the stepper
// and a registered position read port for the renderer.
module point_regfile
    import physics_pkg::*;
#(
    parameter int NUM_POINTS = 8,
    parameter int PIDX_W     = pidx_w(NUM_POINTS)
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              we_in,
    input  logic [PIDX_W-1:0] waddr_in,
    input  point_t            wdata_in,
    input  logic [PIDX_W-1:0] raddr_a_in,
    output point_t            rdata_a_out,
    input  logic [PIDX_W-1:0] raddr_r_in,
    output logic [POS_W-1:0]  rd_pos_x_out,
    output logic [POS_W-1:0]  rd_pos_y_out
);

    point_t           mem_q [NUM_POINTS];
    point_t           mem_d [NUM_POINTS];
    logic [POS_W-1:0] rd_x_q, rd_x_d, rd_y_q, rd_y_d;

    always_comb begin
        mem_d = mem_q;
        if (we_in && (int'(waddr_in) < NUM_POINTS)) begin
            mem_d[waddr_in] = wdata_in;
        end
        rd_x_d = '0;
        rd_y_d = '0;
        // reads mem_q, so a same-cycle write is not visible until next read
        if (int'(raddr_r_in) < NUM_POINTS) begin
            rd_x_d = mem_q[raddr_r_in].pos_x;
            rd_y_d = mem_q[raddr_r_in].pos_y;
        end
        rdata_a_out = '0;
        if (int'(raddr_a_in) < NUM_POINTS) begin
            rdata_a_out = mem_q[raddr_a_in];
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < NUM_POINTS; i++) begin
                mem_q[i] <= '0;
            end
            rd_x_q <= '0;
            rd_y_q <= '0;
        end else begin
            mem_q  <= mem_d;
            rd_x_q <= rd_x_d;
            rd_y_q <= rd_y_d;
        end
    end

    assign rd_pos_x_out = rd_x_q;
    assign rd_pos_y_out = rd_y_q;

endmodule

// File: rtl/point_stepper.sv
// Frame sequencer: walks points 0..N-1 through update_point, one outstanding
// request at a time, and writes each returned state back into the file.
module point_stepper
    import physics_pkg::*;
#(
    parameter int POSITION_SIZE = POS_W,
    parameter int VELOCITY_SIZE = VEL_W,
    parameter int NUM_POINTS    = 8,
    parameter int TIMEOUT       = 255
) (
    input  logic                           clk_in,
    input  logic                           rst_n_in,
    input  logic                           step_in,
    // one bit wider than an index so requests beyond NUM_POINTS can be clamped
    input  logic [pidx_w(NUM_POINTS):0]    num_points_in,
    input  logic                           load_valid_in,
    input  logic [pidx_w(NUM_POINTS)-1:0]  load_idx_in,
    input  logic [POSITION_SIZE-1:0]       load_pos_x_in,
    input  logic [POSITION_SIZE-1:0]       load_pos_y_in,
    input  logic [VELOCITY_SIZE-1:0]       load_vel_x_in,
    input  logic [VELOCITY_SIZE-1:0]       load_vel_y_in,
    output logic                           upd_begin_out,
    output logic [POSITION_SIZE-1:0]       upd_pos_x_out,
    output logic [POSITION_SIZE-1:0]       upd_pos_y_out,
    output logic [VELOCITY_SIZE-1:0]       upd_vel_x_out,
    output logic [VELOCITY_SIZE-1:0]       upd_vel_y_out,
    input  logic                           upd_result_in,
    input  logic [POSITION_SIZE-1:0]       upd_new_pos_x_in,
    input  logic [POSITION_SIZE-1:0]       upd_new_pos_y_in,
    input  logic [VELOCITY_SIZE-1:0]       upd_new_vel_x_in,
    input  logic [VELOCITY_SIZE-1:0]       upd_new_vel_y_in,
    input  logic [pidx_w(NUM_POINTS)-1:0]  rd_idx_in,
    output logic [POSITION_SIZE-1:0]       rd_pos_x_out,
    output logic [POSITION_SIZE-1:0]       rd_pos_y_out,
    output logic                           busy_out,
    output logic                           done_out,
    output logic                           timeout_err_out
);

    localparam int PIDX_W = pidx_w(NUM_POINTS);
    localparam int NW     = PIDX_W + 1;
    localparam int CNT_W  = pidx_w(TIMEOUT);

    stepper_state_t    state_q, state_d;
    logic [PIDX_W-1:0] idx_q, idx_d, waddr;
    logic [NW-1:0]     n_q, n_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    point_t            cap_q, cap_d, wdata, cur, op;
    logic              we;

    point_regfile #(.NUM_POINTS(NUM_POINTS), .PIDX_W(PIDX_W)) u_rf (
        .clk_in      (clk_in),
        .rst_n_in    (rst_n_in),
        .we_in       (we),
        .waddr_in    (waddr),
        .wdata_in    (wdata),
        .raddr_a_in  (idx_q),
        .rdata_a_out (cur),
        .raddr_r_in  (rd_idx_in),
        .rd_pos_x_out(rd_pos_x_out),
        .rd_pos_y_out(rd_pos_y_out)
    );

    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        n_d             = n_q;
        cnt_d           = cnt_q;
        cap_d           = cap_q;
        we              = 1'b0;
        waddr           = idx_q;
        wdata           = cap_q;
        upd_begin_out   = 1'b0;
        done_out        = 1'b0;
        timeout_err_out = 1'b0;
        case (state_q)
            S_IDLE: begin
                // load lands at this edge, so a simultaneous step launches on it
                if (load_valid_in) begin
                    we    = 1'b1;
                    waddr = load_idx_in;
                    wdata = '{pos_x: load_pos_x_in, pos_y: load_pos_y_in,
                              vel_x: load_vel_x_in, vel_y: load_vel_y_in};
                end
                if (step_in) begin
                    n_d     = (int'(num_points_in) > NUM_POINTS) ? NW'(NUM_POINTS) : num_points_in;
                    idx_d   = '0;
                    state_d = (n_d == '0) ? S_DONE : S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                upd_begin_out = 1'b1;
                cnt_d         = '0;
                state_d       = S_WAIT;
            end
            S_WAIT: begin
                if (upd_result_in) begin
                    cap_d   = '{pos_x: upd_new_pos_x_in, pos_y: upd_new_pos_y_in,
                                vel_x: upd_new_vel_x_in, vel_y: upd_new_vel_y_in};
                    state_d = S_WRITE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    timeout_err_out = 1'b1;
                    state_d         = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WRITE: begin
                we = 1'b1;
                if ({1'b0, idx_q} == n_q - 1'b1) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_LAUNCH;
                end
            end
            S_DONE: begin
                done_out = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            n_q     <= '0;
            cnt_q   <= '0;
            cap_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
            cap_q   <= cap_d;
        end
    end

    // operands only driven while a request is outstanding; the entry is stable then
    assign op            = (state_q == S_LAUNCH || state_q == S_WAIT) ? cur : '0;
    assign upd_pos_x_out = op.pos_x;
    assign upd_pos_y_out = op.pos_y;
    assign upd_vel_x_out = op.vel_x;
    assign upd_vel_y_out = op.vel_y;
    assign busy_out      = (state_q != S_IDLE);

endmodule

// File: tb/tb_point_stepper.sv
// Directed bench for point_stepper with a latency-programmable update_point
// responder and a scoreboard of expected begin/done/timeout events.
module tb_point_stepper;

    logic       clk_in = 1'b0;
    logic       rst_n_in = 1'b0;
    logic       step_in = 1'b0;
    logic [3:0] num_points_in = '0;
    logic       load_valid_in = 1'b0;
    logic [2:0] load_idx_in = '0;
    logic [7:0] lpx = '0, lpy = '0, lvx = '0, lvy = '0;
    logic       upd_begin_out;
    logic [7:0] upx, upy, uvx, uvy;
    logic       upd_result_in = 1'b0;
    logic [7:0] npx = '0, npy = '0, nvx = '0, nvy = '0;
    logic [2:0] rd_idx_in = '0;
    logic [7:0] rd_pos_x_out, rd_pos_y_out;
    logic       busy_out, done_out, timeout_err_out;

    point_stepper #(.POSITION_SIZE(8), .VELOCITY_SIZE(8), .NUM_POINTS(8), .TIMEOUT(8)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .step_in(step_in), .num_points_in(num_points_in),
        .load_valid_in(load_valid_in), .load_idx_in(load_idx_in),
        .load_pos_x_in(lpx), .load_pos_y_in(lpy), .load_vel_x_in(lvx), .load_vel_y_in(lvy),
        .upd_begin_out(upd_begin_out),
        .upd_pos_x_out(upx), .upd_pos_y_out(upy), .upd_vel_x_out(uvx), .upd_vel_y_out(uvy),
        .upd_result_in(upd_result_in),
        .upd_new_pos_x_in(npx), .upd_new_pos_y_in(npy), .upd_new_vel_x_in(nvx), .upd_new_vel_y_in(nvy),
        .rd_idx_in(rd_idx_in), .rd_pos_x_out(rd_pos_x_out), .rd_pos_y_out(rd_pos_y_out),
        .busy_out(busy_out), .done_out(done_out), .timeout_err_out(timeout_err_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int          cyc;
        logic [31:0] ops;
    } exp_t;

    exp_t        qb[$], qd[$], qt[$];
    logic [31:0] mdl [8];
    int          cyc = 0;
    int          ncmp = 0, nfail = 0;
    int          resp_lat = 4;
    bit          resp_en = 1'b1;
    bit          spur_req = 1'b0;
    bit          pend = 1'b0;
    int          cd = 0;
    logic [31:0] rops = '0;

    always @(posedge clk_in) cyc <= cyc + 1;

    function automatic logic [31:0] nxt(input logic [31:0] p);
        return {p[31:24] + p[15:8], p[23:16] + p[7:0], p[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    // update_point stand-in: returns pos+vel, R cycles after the begin pulse
    always @(negedge clk_in) begin
        upd_result_in = 1'b0;
        if (!rst_n_in) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                cd--;
                if (cd == 0) begin
                    pend = 1'b0;
                    upd_result_in = 1'b1;
                    {npx, npy, nvx, nvy} = nxt(rops);
                end
            end
            if (upd_begin_out && resp_en) begin
                pend = 1'b1;
                cd   = resp_lat;
                rops = {upx, upy, uvx, uvy};
            end
            if (spur_req) begin
                upd_result_in = 1'b1;
                {npx, npy, nvx, nvy} = 32'h7f7f7f7f;
            end
        end
    end

    always @(negedge clk_in) begin
        exp_t e;
        if (rst_n_in) begin
            if (upd_begin_out) begin
                chk("begin_expected", qb.size() > 0, 1);
                if (qb.size() > 0) begin
                    e = qb.pop_front();
                    chk("begin_cycle", cyc, e.cyc);
                    chk("begin_ops", {upx, upy, uvx, uvy}, e.ops);
                end
            end
            if (done_out) begin
                chk("done_expected", qd.size() > 0, 1);
                if (qd.size() > 0) begin
                    e = qd.pop_front();
                    chk("done_cycle", cyc, e.cyc);
                end
            end
            if (timeout_err_out) begin
                chk("timeout_expected", qt.size() > 0, 1);
                if (qt.size() > 0) begin
                    e = qt.pop_front();
                    chk("timeout_cycle", cyc, e.cyc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic load(input int idx, input logic [31:0] v);
        load_valid_in = 1'b1;
        load_idx_in   = 3'(idx);
        {lpx, lpy, lvx, lvy} = v;
        tick();
        load_valid_in = 1'b0;
        mdl[idx] = v;
    endtask

    task automatic do_step(input int n, input int r);
        int nn, s;
        nn = (n > 8) ? 8 : n;
        s  = cyc;
        resp_lat      = r;
        step_in       = 1'b1;
        num_points_in = 4'(n);
        for (int i = 0; i < nn; i++) begin
            qb.push_back('{s + 1 + i * (r + 2), mdl[i]});
            mdl[i] = nxt(mdl[i]);
        end
        qd.push_back('{s + nn * (r + 2) + 1, 32'h0});
        tick();
        step_in = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((qb.size() + qd.size() + qt.size()) != 0 && k < 300) begin
            tick();
            k++;
        end
        chk("events_pending", qb.size() + qd.size() + qt.size(), 0);
        tick();
        tick();
    endtask

    task automatic rd_chk(input int i);
        rd_idx_in = 3'(i);
        tick();
        chk($sformatf("rd_entry%0d", i), {16'h0, rd_pos_x_out, rd_pos_y_out}, {16'h0, mdl[i][31:16]});
    endtask

    initial begin
        int s;
        for (int i = 0; i < 8; i++) mdl[i] = '0;
        #2;
        chk("reset_outputs", {upd_begin_out, busy_out, done_out, timeout_err_out}, 0);
        chk("reset_ops", {upx, upy, uvx, uvy}, 0);
        chk("reset_rd", {rd_pos_x_out, rd_pos_y_out}, 0);
        tick();
        rst_n_in = 1'b1;
        tick();

        // single point, R=4
        load(0, 32'h0A1403FE);
        do_step(1, 4);
        drain();
        rd_chk(0);
        chk("entry0_value", {16'h0, rd_pos_x_out, rd_pos_y_out}, 32'h00000D12);

        // three points, R=2, busy throughout
        load(1, 32'h01020304);
        load(2, 32'hF0108010);
        do_step(3, 2);
        for (int k = 0; k < 13; k++) begin
            chk("busy_during_step", busy_out, 1);
            tick();
        end
        chk("idle_after_step", busy_out, 0);
        drain();
        for (int i = 0; i < 3; i++) rd_chk(i);

        // silent responder: abort after TIMEOUT cycles
        resp_en = 1'b0;
        s = cyc;
        step_in = 1'b1;
        num_points_in = 4'd1;
        qb.push_back('{s + 1, mdl[0]});
        qt.push_back('{s + 9, 32'h0});
        tick();
        step_in = 1'b0;
        drain();
        resp_en = 1'b1;
        chk("idle_after_timeout", busy_out, 0);
        rd_chk(0);

        // step/load during WAIT and a stray result in IDLE are ignored
        do_step(1, 6);
        tick();
        load_valid_in = 1'b1;
        load_idx_in   = 3'd2;
        {lpx, lpy, lvx, lvy} = 32'h55555555;
        step_in = 1'b1;
        num_points_in = 4'd3;
        tick();
        load_valid_in = 1'b0;
        step_in = 1'b0;
        drain();
        spur_req = 1'b1;
        tick();
        spur_req = 1'b0;
        tick();
        chk("idle_after_spurious", busy_out, 0);
        for (int i = 0; i < 8; i++) rd_chk(i);

        // reset during WAIT of point 1 of 3
        load(0, 32'h11223344);
        load(1, 32'h05060708);
        s = cyc;
        do_step(3, 4);
        while (cyc < s + 9) tick();
        rst_n_in = 1'b0;
        qb.delete();
        qd.delete();
        qt.delete();
        for (int i = 0; i < 8; i++) mdl[i] = '0;
        #1;
        chk("rst_outputs", {upd_begin_out, busy_out, done_out, timeout_err_out}, 0);
        chk("rst_ops", {upx, upy, uvx, uvy}, 0);
        chk("rst_rd", {rd_pos_x_out, rd_pos_y_out}, 0);
        tick();
        tick();
        rst_n_in = 1'b1;
        for (int i = 0; i < 8; i++) rd_chk(i);
        load(0, 32'h05060101);
        load(1, 32'h7F80FF01);
        do_step(2, 3);
        drain();
        rd_chk(0);
        rd_chk(1);

        // request beyond the file depth is clamped to NUM_POINTS
        for (int i = 0; i < 8; i++) load(i, {8'(i * 3), 8'(100 - i), 8'(i), 8'hFF});
        do_step(12, 1);
        drain();
        for (int i = 0; i < 8; i++) rd_chk(i);

        // zero-point step: done one cycle after acceptance
        do_step(0, 1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
